csr_seq: RTL and testbench

//  Sequencer that owns the single-port CSR file and is its only driver. WB issues one request at a time:

---
 rtl/csr_seq_pkg.sv | 45 ++++
 rtl/csr_seq.sv | 175 +++++++++++++++++
 tb/tb_csr_seq.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_seq_pkg.sv
// Shared definitions for the CSR sequencer: request opcodes, CSR addresses,
// exception codes and the FSM state encoding.
// No logic; imported by csr_seq.
package csr_seq_pkg;

  // WB request opcodes (5-7 reserved: accepted and dropped)
  localparam logic [2:0] OP_RD      = 3'd0;
  localparam logic [2:0] OP_WR      = 3'd1;
  localparam logic [2:0] OP_XCHG    = 3'd2;
  localparam logic [2:0] OP_SYSCALL = 3'd3;
  localparam logic [2:0] OP_ERTN    = 3'd4;

  // CSR addresses
  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;

  // ESTAT.Ecode written on syscall entry
  localparam logic [5:0] ECODE_SYS = 6'h0B;

  // FSM states; unused encodings 13-15 fall back to IDLE
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ACC      = 4'd1,
    S_EX_CRMD  = 4'd2,
    S_EX_PRMD  = 4'd3,
    S_EX_ERA   = 4'd4,
    S_EX_ESTAT = 4'd5,
    S_EX_CRMD2 = 4'd6,
    S_EX_EENT  = 4'd7,
    S_ER_PRMD  = 4'd8,
    S_ER_CRMD  = 4'd9,
    S_ER_ERA   = 4'd10,
    S_FLUSH    = 4'd11,
    S_DROP     = 4'd12
  } state_t;

  // PLV/IE field (bits 2:0) of a CRMD/PRMD value, zero-extended
  function automatic logic [31:0] plv_ie(input logic [31:0] v);
    return {29'd0, v[2:0]};
  endfunction

endpackage

// File: rtl/csr_seq.sv
// CSR sequencer: sole driver of the single-port CSR file; turns one WB request
//   (csrrd/csrwr/csrxchg/syscall/ertn) into ordered CSR accesses, a response or a flush.
// Latency: RD/WR/XCHG resp 1 cycle after accept; SYSCALL flush at +7, ERTN flush at +4.
// Backpressure: req_ready high only in IDLE; WB holds its request, nothing is queued.
// Ports: clk/rst (async active-low); req_* from WB; resp_* to WB; csr_* to/from
//   the CSR file (csr_rvalue is combinational); flush/flush_target redirect the pipeline.
module csr_seq
  import csr_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [13:0] req_num,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_wmask,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        csr_re,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  input  logic [31:0] csr_rvalue,
  output logic        flush,
  output logic [31:0] flush_target
);

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [13:0] num_q;
  logic [31:0] wdata_q;
  logic [31:0] wmask_q;
  logic [31:0] pc_q;
  logic [31:0] tmp_q;

  logic accept;
  assign accept = (state == S_IDLE) && req_valid;

  // Next-state decode
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE: begin
        state_nxt = S_IDLE;
        if (req_valid) begin
          case (req_op)
            OP_RD, OP_WR, OP_XCHG: state_nxt = S_ACC;
            OP_SYSCALL:            state_nxt = S_EX_CRMD;
            OP_ERTN:               state_nxt = S_ER_PRMD;
            default:               state_nxt = S_DROP;
          endcase
        end
      end
      S_EX_CRMD:  state_nxt = S_EX_PRMD;
      S_EX_PRMD:  state_nxt = S_EX_ERA;
      S_EX_ERA:   state_nxt = S_EX_ESTAT;
      S_EX_ESTAT: state_nxt = S_EX_CRMD2;
      S_EX_CRMD2: state_nxt = S_EX_EENT;
      S_EX_EENT:  state_nxt = S_FLUSH;
      S_ER_PRMD:  state_nxt = S_ER_CRMD;
      S_ER_CRMD:  state_nxt = S_ER_ERA;
      S_ER_ERA:   state_nxt = S_FLUSH;
      default:    state_nxt = S_IDLE;  // ACC, FLUSH, DROP, illegal encodings
    endcase
  end

  // State register and datapath (latched request, scratch tmp)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      op_q    <= 3'd0;
      num_q   <= 14'd0;
      wdata_q <= 32'd0;
      wmask_q <= 32'd0;
      pc_q    <= 32'd0;
      tmp_q   <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= req_op;
        num_q   <= req_num;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
        pc_q    <= req_pc;
      end
      // tmp carries a read result into the following state(s)
      case (state)
        S_EX_CRMD, S_EX_EENT, S_ER_PRMD, S_ER_ERA: tmp_q <= csr_rvalue;
        default: ;
      endcase
    end
  end

  // Outputs decode registered state/fields only; no req_* feeds them.
  always_comb begin
    req_ready    = (state == S_IDLE);
    resp_valid   = 1'b0;
    resp_rdata   = 32'd0;
    csr_re       = 1'b0;
    csr_we       = 1'b0;
    csr_num      = 14'd0;
    csr_wmask    = 32'd0;
    csr_wvalue   = 32'd0;
    flush        = 1'b0;
    flush_target = 32'd0;
    case (state)
      S_ACC: begin
        csr_re     = 1'b1;
        csr_we     = (op_q != OP_RD);
        csr_num    = num_q;
        csr_wmask  = (op_q == OP_WR) ? '1 : wmask_q;
        csr_wvalue = wdata_q;
        resp_valid = 1'b1;
        resp_rdata = csr_rvalue;
      end
      S_EX_CRMD: begin
        csr_re  = 1'b1;
        csr_num = CSR_CRMD;
      end
      S_EX_PRMD: begin
        csr_we     = 1'b1;
        csr_num    = CSR_PRMD;
        csr_wmask  = 32'h0000_0007;
        csr_wvalue = plv_ie(tmp_q);
      end
      S_EX_ERA: begin
        csr_we     = 1'b1;
        csr_num    = CSR_ERA;
        csr_wmask  = '1;
        csr_wvalue = pc_q;
      end
      S_EX_ESTAT: begin
        // Ecode in [21:16], EsubCode [30:22] cleared
        csr_we     = 1'b1;
        csr_num    = CSR_ESTAT;
        csr_wmask  = 32'h7FFF_0000;
        csr_wvalue = {10'd0, ECODE_SYS, 16'd0};
      end
      S_EX_CRMD2: begin
        // PLV0, interrupts disabled
        csr_we     = 1'b1;
        csr_num    = CSR_CRMD;
        csr_wmask  = 32'h0000_0007;
        csr_wvalue = 32'd0;
      end
      S_EX_EENT: begin
        csr_re  = 1'b1;
        csr_num = CSR_EENTRY;
      end
      S_ER_PRMD: begin
        csr_re  = 1'b1;
        csr_num = CSR_PRMD;
      end
      S_ER_CRMD: begin
        csr_we     = 1'b1;
        csr_num    = CSR_CRMD;
        csr_wmask  = 32'h0000_0007;
        csr_wvalue = plv_ie(tmp_q);
      end
      S_ER_ERA: begin
        csr_re  = 1'b1;
        csr_num = CSR_ERA;
      end
      S_FLUSH: begin
        flush        = 1'b1;
        flush_target = tmp_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_seq.sv
// Directed bench for csr_seq: a behavioural CSR file answers reads and commits
// masked writes on the clock edge; each scenario checks strobes, responses,
// flush timing/target and resulting CSR contents against hand-computed values.
module tb_csr_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [13:0] req_num;
  logic [31:0] req_wdata;
  logic [31:0] req_wmask;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        csr_re;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] csr_rvalue;
  logic        flush;
  logic [31:0] flush_target;

  always #5 clk = ~clk;

  csr_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_num(req_num), .req_wdata(req_wdata), .req_wmask(req_wmask), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue),
    .flush(flush), .flush_target(flush_target)
  );

  // Behavioural CSR file (all used addresses fit in 4 bits)
  logic [31:0] mem [0:15];
  logic        pre_en;
  logic [3:0]  pre_num;
  logic [31:0] pre_val;

  assign csr_rvalue = mem[csr_num[3:0]];

  always @(posedge clk) begin
    if (pre_en)
      mem[pre_num] <= pre_val;
    else if (csr_we)
      mem[csr_num[3:0]] <= (mem[csr_num[3:0]] & ~csr_wmask) | (csr_wvalue & csr_wmask);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] n, input logic [31:0] v);
    pre_en  = 1'b1;
    pre_num = n;
    pre_val = v;
    step();
    pre_en  = 1'b0;
  endtask

  // Present a request in IDLE; returns #1 after the accepting edge (cycle 1).
  task automatic send(input logic [2:0] op, input logic [13:0] num,
                      input logic [31:0] wd, input logic [31:0] wm, input logic [31:0] pc);
    req_op    = op;
    req_num   = num;
    req_wdata = wd;
    req_wmask = wm;
    req_pc    = pc;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  int          n_flush, flush_cyc, n_resp, n_rdy_low, n_strobe, n_overlap;
  logic [31:0] flush_tgt;

  // Observe cycles 1..n after an accept
  task automatic watch(input int n);
    n_flush = 0; flush_cyc = -1; flush_tgt = 32'd0;
    n_resp = 0; n_rdy_low = 0; n_strobe = 0; n_overlap = 0;
    for (int c = 1; c <= n; c++) begin
      if (flush) begin
        n_flush++;
        flush_cyc = c;
        flush_tgt = flush_target;
        if (csr_re || csr_we || resp_valid) n_overlap++;
      end
      if (resp_valid) n_resp++;
      if (!req_ready) n_rdy_low++;
      if (csr_re || csr_we) n_strobe++;
      step();
    end
  endtask

  int          first_rdy, fl_c, resp_c;
  logic [31:0] rd_val;

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_num = 14'd0;
    req_wdata = 32'd0; req_wmask = 32'd0; req_pc = 32'd0;
    pre_en = 1'b0; pre_num = 4'd0; pre_val = 32'd0;
    step(); step();

    // Reset state
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_strobes", {30'd0, csr_re, csr_we}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_outs_or", resp_rdata | flush_target | csr_wmask | csr_wvalue | {18'd0, csr_num}, 32'd0);
    rst = 1'b1;

    // 1: reset asserted while in EX_ERA
    preload(4'h0, 32'h0000_0005);
    preload(4'h1, 32'h0000_0000);
    preload(4'h6, 32'h1111_1111);
    send(3'd3, 14'd0, 32'd0, 32'd0, 32'h2222_2220);
    step(); step();  // cycle 3 = EX_ERA
    chk("t1_era_we", {31'd0, csr_we}, 32'd1);
    chk("t1_era_num", {18'd0, csr_num}, 32'h6);
    rst = 1'b0;
    #1;
    chk("t1_ready", {31'd0, req_ready}, 32'd1);
    chk("t1_outs", {29'd0, csr_re, csr_we, flush}, 32'd0);
    step(); step();
    rst = 1'b1;
    watch(4);
    chk("t1_no_flush", n_flush, 32'd0);
    chk("t1_no_strobe", n_strobe, 32'd0);
    chk("t1_era_kept", mem[6], 32'h1111_1111);
    chk("t1_prmd_committed", mem[1], 32'h0000_0005);

    // 2: RD ESTAT
    preload(4'h5, 32'h0000_1234);
    send(3'd0, 14'h005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    chk("t2_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("t2_rdata", resp_rdata, 32'h0000_1234);
    chk("t2_we", {31'd0, csr_we}, 32'd0);
    chk("t2_re", {31'd0, csr_re}, 32'd1);
    chk("t2_ready_low", {31'd0, req_ready}, 32'd0);
    step();
    chk("t2_ready_back", {31'd0, req_ready}, 32'd1);
    chk("t2_resp_pulse", {31'd0, resp_valid}, 32'd0);
    chk("t2_estat_same", mem[5], 32'h0000_1234);

    // 3: XCHG PRMD
    preload(4'h1, 32'h0000_0002);
    send(3'd2, 14'h001, 32'h0000_00FF, 32'h0000_0005, 32'd0);
    chk("t3_rdata", resp_rdata, 32'h0000_0002);
    chk("t3_we", {31'd0, csr_we}, 32'd1);
    chk("t3_wmask", csr_wmask, 32'h0000_0005);
    watch(1);
    chk("t3_ready_low_cycles", n_rdy_low, 32'd1);
    chk("t3_ready_back", {31'd0, req_ready}, 32'd1);
    chk("t3_prmd", mem[1], 32'h0000_0007);

    // WR ERA: mask forced to all ones
    send(3'd1, 14'h006, 32'hDEAD_BEEF, 32'h0000_0000, 32'd0);
    chk("wr_rdata", resp_rdata, 32'h1111_1111);
    chk("wr_wmask", csr_wmask, 32'hFFFF_FFFF);
    step();
    chk("wr_era", mem[6], 32'hDEAD_BEEF);

    // 4: SYSCALL
    preload(4'h0, 32'h0000_0007);
    preload(4'h1, 32'h0000_0000);
    preload(4'hC, 32'h1C00_8000);
    send(3'd3, 14'd0, 32'd0, 32'd0, 32'h1C00_0040);
    watch(8);
    chk("t4_flush_count", n_flush, 32'd1);
    chk("t4_flush_cycle", flush_cyc, 32'd7);
    chk("t4_flush_target", flush_tgt, 32'h1C00_8000);
    chk("t4_flush_overlap", n_overlap, 32'd0);
    chk("t4_no_resp", n_resp, 32'd0);
    chk("t4_strobes", n_strobe, 32'd6);
    chk("t4_ready_low", n_rdy_low, 32'd7);
    chk("t4_prmd", mem[1], 32'h0000_0007);
    chk("t4_era", mem[6], 32'h1C00_0040);
    chk("t4_estat", mem[5], 32'h000B_1234);
    chk("t4_crmd", mem[0], 32'h0000_0000);

    // 5: ERTN
    preload(4'h6, 32'h1C00_0044);
    send(3'd4, 14'd0, 32'd0, 32'd0, 32'd0);
    watch(5);
    chk("t5_flush_count", n_flush, 32'd1);
    chk("t5_flush_cycle", flush_cyc, 32'd4);
    chk("t5_flush_target", flush_tgt, 32'h1C00_0044);
    chk("t5_strobes", n_strobe, 32'd3);
    chk("t5_ready_low", n_rdy_low, 32'd4);
    chk("t5_crmd", mem[0], 32'h0000_0007);

    // 6: SYSCALL then RD with req_valid held high
    req_op = 3'd3; req_num = 14'd0; req_pc = 32'h1C00_0080; req_valid = 1'b1;
    step();
    req_op = 3'd0; req_num = 14'h005;
    first_rdy = -1; fl_c = -1; resp_c = -1; rd_val = 32'd0;
    for (int c = 1; c <= 12; c++) begin
      if (flush && fl_c < 0) fl_c = c;
      if (req_ready && first_rdy < 0) first_rdy = c;
      if (resp_valid && resp_c < 0) begin
        resp_c = c;
        rd_val = resp_rdata;
        req_valid = 1'b0;
      end
      step();
    end
    req_valid = 1'b0;
    chk("t6_flush_cycle", fl_c, 32'd7);
    chk("t6_first_ready", first_rdy, 32'd8);
    chk("t6_resp_cycle", resp_c, 32'd9);
    chk("t6_rd_value", rd_val, 32'h000B_1234);
    chk("t6_era", mem[6], 32'h1C00_0080);

    // Reserved op dropped
    send(3'd6, 14'h005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    watch(2);
    chk("rsv_no_strobe", n_strobe, 32'd0);
    chk("rsv_no_resp", n_resp, 32'd0);
    chk("rsv_no_flush", n_flush, 32'd0);
    chk("rsv_ready_low", n_rdy_low, 32'd1);
    chk("rsv_ready_back", {31'd0, req_ready}, 32'd1);
    chk("rsv_estat_same", mem[5], 32'h000B_1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
